// File: rtl/scarv_cop_idispatch.sv
// Coprocessor instruction dispatcher: buffers host instructions in a small
// FIFO, presents the head to the decoder, then issues to the functional
// units, runs a CPR zeroing sweep, or responds directly with an error.
module scarv_cop_idispatch #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cpu_insn_req,
  input  logic [31:0] cpu_insn_enc,
  output logic        cpu_insn_ack,
  output logic [31:0] id_encoded,
  input  logic        id_exception,
  input  logic [8:0]  id_class,
  input  logic        id_cprs_init,
  output logic        fu_valid,
  output logic [31:0] fu_insn,
  output logic [8:0]  fu_class,
  input  logic        fu_done,
  output logic        cprs_init_wen,
  output logic [3:0]  cprs_init_addr,
  output logic        cpu_rsp_valid,
  output logic        cpu_rsp_error,
  input  logic        cpu_rsp_ack
);

  localparam int unsigned INSN_W  = 32;
  localparam int unsigned CLASS_W = 9;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(15);

  typedef enum logic [1:0] {IDLE, ISSUE, INIT, RESP} state_t;

  state_t              state, state_d;
  logic [INSN_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, count_d;
  logic [INSN_W-1:0]   insn_q;
  logic [CLASS_W-1:0]  class_q;
  logic                exc_q;
  logic [ADDR_W-1:0]   init_cnt, init_cnt_d;
  logic                pop_c, push_c;

  // Buffer handshake: a pop in the same cycle frees a slot for the push.
  assign pop_c        = (state == IDLE) && (count != '0);
  assign cpu_insn_ack = g_resetn && cpu_insn_req &&
                        ((count < CNT_W'(FIFO_DEPTH)) || pop_c);
  assign push_c       = cpu_insn_ack;
  assign id_encoded   = (count != '0) ? mem[rd_ptr] : INSN_W'(0);

  // Outputs decoded one-hot from the state register.
  assign fu_valid       = (state == ISSUE);
  assign cprs_init_wen  = (state == INIT);
  assign cpu_rsp_valid  = (state == RESP);
  assign cpu_rsp_error  = (state == RESP) && exc_q;
  assign fu_insn        = insn_q;
  assign fu_class       = class_q;
  assign cprs_init_addr = init_cnt;

  // Next-state, occupancy and sweep-counter logic.
  always_comb begin
    state_d    = state;
    count_d    = count;
    init_cnt_d = '0;
    if (push_c && !pop_c) count_d = count + CNT_W'(1);
    if (!push_c && pop_c) count_d = count - CNT_W'(1);
    case (state)
      IDLE: begin
        if (pop_c) begin
          if (id_exception)      state_d = RESP;
          else if (id_cprs_init) state_d = INIT;
          else                   state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (fu_done) state_d = RESP;
      end
      INIT: begin
        init_cnt_d = init_cnt + ADDR_W'(1);
        if (init_cnt == LAST_ADDR) begin
          state_d    = RESP;
          init_cnt_d = '0;
        end
      end
      RESP: begin
        if (cpu_rsp_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, buffer and dispatch-latch registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      init_cnt <= '0;
      insn_q   <= '0;
      class_q  <= '0;
      exc_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      init_cnt <= init_cnt_d;
      if (push_c) begin
        mem[wr_ptr] <= cpu_insn_enc;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        insn_q  <= mem[rd_ptr];
        class_q <= id_class;
        exc_q   <= id_exception;
      end
    end
  end

endmodule

// File: tb/tb_scarv_cop_idispatch.sv
// Directed bench for the coprocessor instruction dispatcher.
module tb_scarv_cop_idispatch;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        cpu_insn_req;
  logic [31:0] cpu_insn_enc;
  logic        cpu_insn_ack;
  logic [31:0] id_encoded;
  logic        id_exception;
  logic [8:0]  id_class;
  logic        id_cprs_init;
  logic        fu_valid;
  logic [31:0] fu_insn;
  logic [8:0]  fu_class;
  logic        fu_done;
  logic        cprs_init_wen;
  logic [3:0]  cprs_init_addr;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_error;
  logic        cpu_rsp_ack;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_MOVE = 32'h0000_002B;
  localparam logic [31:0] I_EXC  = 32'h8000_002B;
  localparam logic [31:0] I_INIT = 32'h4000_002B;
  localparam logic [8:0]  C_MOVE = 9'h001;

  scarv_cop_idispatch #(.FIFO_DEPTH(2)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_enc(cpu_insn_enc),
    .cpu_insn_ack(cpu_insn_ack), .id_encoded(id_encoded),
    .id_exception(id_exception), .id_class(id_class),
    .id_cprs_init(id_cprs_init), .fu_valid(fu_valid), .fu_insn(fu_insn),
    .fu_class(fu_class), .fu_done(fu_done), .cprs_init_wen(cprs_init_wen),
    .cprs_init_addr(cprs_init_addr), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_error(cpu_rsp_error), .cpu_rsp_ack(cpu_rsp_ack)
  );

  always #5 g_clk = ~g_clk;

  // Decoder model: bit31 = exception, bit30 = CPR init, opcode 0x2B = MOVE.
  always_comb begin
    id_exception = id_encoded[31];
    id_cprs_init = id_encoded[30];
    id_class     = (id_encoded[6:0] == 7'h2B) ? C_MOVE : 9'h100;
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0; cpu_insn_req = 1'b1; cpu_insn_enc = I_MOVE;
    fu_done = 1'b0; cpu_rsp_ack = 1'b0;
    #3;
    checks++;
    if ({cpu_insn_ack, fu_valid, cprs_init_wen, cpu_rsp_valid, cpu_rsp_error} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000",
        {cpu_insn_ack, fu_valid, cprs_init_wen, cpu_rsp_valid, cpu_rsp_error});
    end
    checks++;
    if (id_encoded !== 32'h0 || cprs_init_addr !== 4'h0 || fu_insn !== 32'h0) begin
      failures++; $display("FAIL reset_data id_enc=%h addr=%h fu_insn=%h exp=0", id_encoded, cprs_init_addr, fu_insn);
    end
    cpu_insn_req = 1'b0;
    step(); step();
    g_resetn = 1'b1;
    step();
  endtask

  // Legal insn, fu_done in the third ISSUE cycle.
  task automatic test_issue();
    int nvalid;
    cpu_insn_req = 1'b1; cpu_insn_enc = I_MOVE; #1;
    checks++;
    if (cpu_insn_ack !== 1'b1) begin failures++; $display("FAIL issue_ack got=%b exp=1", cpu_insn_ack); end
    step(); cpu_insn_req = 1'b0; #1;
    checks++;
    if (id_encoded !== I_MOVE || fu_valid !== 1'b0) begin
      failures++; $display("FAIL issue_head id_enc=%h fu_valid=%b exp=%h/0", id_encoded, fu_valid, I_MOVE);
    end
    step();
    checks++;
    if (fu_valid !== 1'b1 || fu_insn !== I_MOVE || fu_class !== C_MOVE) begin
      failures++; $display("FAIL issue_n2 fu_valid=%b insn=%h class=%h exp=1/%h/%h", fu_valid, fu_insn, fu_class, I_MOVE, C_MOVE);
    end
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      if (fu_valid === 1'b1) nvalid++;
      fu_done = (i == 2);
      step();
    end
    fu_done = 1'b0; #1;
    checks++;
    if (nvalid != 3) begin failures++; $display("FAIL issue_len got=%0d exp=3", nvalid); end
    checks++;
    if (fu_valid !== 1'b0 || cpu_rsp_valid !== 1'b1 || cpu_rsp_error !== 1'b0) begin
      failures++; $display("FAIL issue_rsp fu=%b rsp=%b err=%b exp=0/1/0", fu_valid, cpu_rsp_valid, cpu_rsp_error);
    end
    cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0; #1;
    checks++;
    if (cpu_rsp_valid !== 1'b0) begin failures++; $display("FAIL issue_rsp_drop got=%b exp=0", cpu_rsp_valid); end
    // fu_done in IDLE must be ignored
    fu_done = 1'b1; step(); step(); fu_done = 1'b0; #1;
    checks++;
    if (cpu_rsp_valid !== 1'b0 || fu_valid !== 1'b0) begin
      failures++; $display("FAIL idle_fu_done rsp=%b fu=%b exp=0/0", cpu_rsp_valid, fu_valid);
    end
  endtask

  task automatic test_exception();
    cpu_insn_req = 1'b1; cpu_insn_enc = I_EXC;
    step(); cpu_insn_req = 1'b0;
    step();
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_error !== 1'b1 || fu_valid !== 1'b0 || cprs_init_wen !== 1'b0) begin
      failures++; $display("FAIL exc_rsp rsp=%b err=%b fu=%b wen=%b exp=1/1/0/0",
        cpu_rsp_valid, cpu_rsp_error, fu_valid, cprs_init_wen);
    end
    cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0;
  endtask

  // CPR zeroing sweep with fu_done held high throughout.
  task automatic test_init();
    int bad;
    cpu_insn_req = 1'b1; cpu_insn_enc = I_INIT;
    step(); cpu_insn_req = 1'b0;
    step();
    fu_done = 1'b1;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cprs_init_wen !== 1'b1 || cprs_init_addr !== 4'(i) || fu_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin
        failures++; $display("FAIL init_sweep i=%0d wen=%b addr=%0d fu=%b rsp=%b exp=1/%0d/0/0",
          i, cprs_init_wen, cprs_init_addr, fu_valid, cpu_rsp_valid, i);
      end
      step();
    end
    fu_done = 1'b0;
    checks++;
    if (cprs_init_wen !== 1'b0 || cpu_rsp_valid !== 1'b1 || cpu_rsp_error !== 1'b0 || cprs_init_addr !== 4'h0) begin
      failures++; $display("FAIL init_rsp wen=%b rsp=%b err=%b addr=%0d exp=0/1/0/0",
        cprs_init_wen, cpu_rsp_valid, cpu_rsp_error, cprs_init_addr);
    end
    cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0;
  endtask

  // Fill the buffer behind an insn held in ISSUE; check refusal, push+pop at full, order.
  task automatic test_back_to_back();
    logic [31:0] exp_q [3];
    exp_q[0] = 32'h0000_102B; exp_q[1] = 32'h0000_202B; exp_q[2] = 32'h0000_302B;
    cpu_insn_req = 1'b1; cpu_insn_enc = I_MOVE;
    step(); cpu_insn_req = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      cpu_insn_req = 1'b1; cpu_insn_enc = exp_q[i]; #1;
      checks++;
      if (cpu_insn_ack !== 1'b1) begin failures++; $display("FAIL b2b_push%0d ack=%b exp=1", i, cpu_insn_ack); end
      step();
    end
    cpu_insn_enc = exp_q[2];
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (cpu_insn_ack !== 1'b0 || id_encoded !== exp_q[0]) begin
        failures++; $display("FAIL b2b_full%0d ack=%b head=%h exp=0/%h", i, cpu_insn_ack, id_encoded, exp_q[0]);
      end
      fu_done = (i == 1);
      step();
    end
    fu_done = 1'b0; #1;
    checks++;
    if (cpu_insn_ack !== 1'b0 || cpu_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_resp ack=%b rsp=%b exp=0/1", cpu_insn_ack, cpu_rsp_valid);
    end
    cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0; #1;
    checks++;
    if (cpu_insn_ack !== 1'b1) begin failures++; $display("FAIL b2b_pushpop ack=%b exp=1", cpu_insn_ack); end
    step(); cpu_insn_req = 1'b0; #1;
    checks++;
    if (id_encoded !== exp_q[1]) begin failures++; $display("FAIL b2b_head got=%h exp=%h", id_encoded, exp_q[1]); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fu_valid !== 1'b1 || fu_insn !== exp_q[i]) begin
        failures++; $display("FAIL b2b_order%0d fu=%b insn=%h exp=1/%h", i, fu_valid, fu_insn, exp_q[i]);
      end
      fu_done = 1'b1; step(); fu_done = 1'b0;
      cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0;
      step();
    end
    checks++;
    if (fu_valid !== 1'b0 || id_encoded !== 32'h0) begin
      failures++; $display("FAIL b2b_drain fu=%b head=%h exp=0/0", fu_valid, id_encoded);
    end
  endtask

  // Response held 5 cycles with a buffered insn waiting behind it.
  task automatic test_rsp_hold();
    logic [31:0] z;
    z = 32'h0000_502B;
    cpu_insn_req = 1'b1; cpu_insn_enc = I_EXC;
    step();
    cpu_insn_enc = z; #1;
    checks++;
    if (cpu_insn_ack !== 1'b1) begin failures++; $display("FAIL hold_push ack=%b exp=1", cpu_insn_ack); end
    step(); cpu_insn_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cpu_rsp_valid !== 1'b1 || cpu_rsp_error !== 1'b1 || fu_valid !== 1'b0 || id_encoded !== z) begin
        failures++; $display("FAIL hold_stable%0d rsp=%b err=%b fu=%b head=%h exp=1/1/0/%h",
          i, cpu_rsp_valid, cpu_rsp_error, fu_valid, id_encoded, z);
      end
      step();
    end
    cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0;
    checks++;
    if (cpu_rsp_valid !== 1'b0 || fu_valid !== 1'b0) begin
      failures++; $display("FAIL hold_idle rsp=%b fu=%b exp=0/0", cpu_rsp_valid, fu_valid);
    end
    step();
    checks++;
    if (fu_valid !== 1'b1 || fu_insn !== z) begin
      failures++; $display("FAIL hold_next fu=%b insn=%h exp=1/%h", fu_valid, fu_insn, z);
    end
    fu_done = 1'b1; step(); fu_done = 1'b0;
    cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0;
  endtask

  // Reset pulse at sweep address 7 with a second insn buffered.
  task automatic test_reset_mid_init();
    int bad;
    cpu_insn_req = 1'b1; cpu_insn_enc = I_INIT;
    step();
    cpu_insn_enc = I_MOVE;
    step(); cpu_insn_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (cprs_init_wen !== 1'b1 || cprs_init_addr !== 4'd7) begin
      failures++; $display("FAIL rst_pre wen=%b addr=%0d exp=1/7", cprs_init_wen, cprs_init_addr);
    end
    #1 g_resetn = 1'b0; #1;
    checks++;
    if ({cprs_init_wen, fu_valid, cpu_rsp_valid, cpu_rsp_error} !== 4'b0 || cprs_init_addr !== 4'h0 || id_encoded !== 32'h0) begin
      failures++; $display("FAIL rst_async wen=%b fu=%b rsp=%b addr=%0d head=%h exp=0",
        cprs_init_wen, fu_valid, cpu_rsp_valid, cprs_init_addr, id_encoded);
    end
    step();
    g_resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_rsp_valid !== 1'b0 || fu_valid !== 1'b0 || cprs_init_wen !== 1'b0 || id_encoded !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_quiet bad_cycles=%0d exp=0", bad); end
    cpu_insn_req = 1'b1; cpu_insn_enc = I_MOVE; #1;
    checks++;
    if (cpu_insn_ack !== 1'b1) begin failures++; $display("FAIL rst_accept ack=%b exp=1", cpu_insn_ack); end
    step(); cpu_insn_req = 1'b0;
    step();
    checks++;
    if (fu_valid !== 1'b1 || fu_insn !== I_MOVE) begin
      failures++; $display("FAIL rst_reissue fu=%b insn=%h exp=1/%h", fu_valid, fu_insn, I_MOVE);
    end
    fu_done = 1'b1; step(); fu_done = 1'b0;
    cpu_rsp_ack = 1'b1; step(); cpu_rsp_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_issue();
    test_exception();
    test_init();
    test_back_to_back();
    test_rsp_hold();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
